// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op codes, FSM states and small helpers for
// the sequential RISC-V M-extension unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int STEPS = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operand A is signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    op_a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV)  || (op == OP_REM);
  endfunction

  // Operand B is signed for MULH, DIV and REM only.
  function automatic logic op_b_signed(input logic [2:0] op);
    op_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Two's-complement negate when neg is set; used both for magnitudes
  // going into the engine and for sign-restoring the 32-bit results.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    cond_neg = neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core and muldiv_seq.
// master = core side, slave = the multiply/divide unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, rs1, rs2, kill,
                  input  busy, done, result);
  modport slave  (input  start, op, rs1, rs2, kill,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: 64-bit accumulator with one radix-2 step per enabled cycle.
// Multiply: shift-add, accumulator starts as {0, A}, B added into the top half.
// Divide: restoring, accumulator starts as {0, A}; ends as {remainder, quotient}.
// The initial value is injected on the first step, so no separate load cycle.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic              first_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] acc_in_s;
  logic [XLEN:0]     sum_s;
  logic [XLEN:0]     trial_s;

  // Next accumulator value for one shift-add or restoring-subtract step.
  always_comb begin
    acc_in_s = first_i ? {{XLEN{1'b0}}, a_i} : acc_q;
    sum_s    = {1'b0, acc_in_s[2*XLEN-1:XLEN]} + {1'b0, b_i};
    trial_s  = acc_in_s[2*XLEN-1:XLEN-1] - {1'b0, b_i};
    acc_d    = acc_q;
    if (step_i) begin
      if (div_i) begin
        if (!trial_s[XLEN]) begin
          acc_d = {trial_s[XLEN-1:0], acc_in_s[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_in_s[2*XLEN-2:0], 1'b0};
        end
      end else begin
        if (acc_in_s[0]) begin
          acc_d = {sum_s, acc_in_s[XLEN-1:1]};
        end else begin
          acc_d = {1'b0, acc_in_s[2*XLEN-1:1]};
        end
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {(2*XLEN){1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RISC-V M-extension multiply/divide unit.
// FSM IDLE -> CALC (32 steps) -> FIX (sign/half select) -> DONE (done pulse).
// Divide-by-zero and signed overflow resolve straight from IDLE to DONE.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed multiplier and also go IDLE -> DONE.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              accept_s;
  logic              div0_s;
  logic              ovf_s;
  logic              direct_s;
  logic [XLEN-1:0]   direct_val_s;
  logic              neg_a_s, neg_b_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [2*XLEN-1:0] acc_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fix_val_s;

  assign accept_s = (state_q == ST_IDLE) && bus.start && !bus.kill;
  assign div0_s   = bus.op[2] && (bus.rs2 == 32'h0000_0000);
  assign ovf_s    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a_s, fast_b_s;
  logic signed [2*XLEN-1:0] fast_p_s;
  logic [XLEN-1:0]          fast_val_s;

  // Single-cycle signed 33x33 product; the 33rd bit carries signedness.
  always_comb begin
    fast_a_s   = op_a_signed(bus.op) ? $signed({bus.rs1[XLEN-1], bus.rs1})
                                     : $signed({1'b0, bus.rs1});
    fast_b_s   = op_b_signed(bus.op) ? $signed({bus.rs2[XLEN-1], bus.rs2})
                                     : $signed({1'b0, bus.rs2});
    fast_p_s   = fast_a_s * fast_b_s;
    fast_val_s = (bus.op == OP_MUL) ? fast_p_s[XLEN-1:0] : fast_p_s[2*XLEN-1:XLEN];
  end
`endif

  // Ops that finish without iterating, and the value they produce.
  always_comb begin
    direct_s     = 1'b0;
    direct_val_s = {XLEN{1'b0}};
    if (div0_s) begin
      direct_s     = 1'b1;
      direct_val_s = bus.op[1] ? bus.rs1 : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      direct_s     = 1'b1;
      direct_val_s = bus.op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!bus.op[2]) begin
      direct_s     = 1'b1;
      direct_val_s = fast_val_s;
    end
`endif
    else begin
      direct_s     = 1'b0;
      direct_val_s = {XLEN{1'b0}};
    end
  end

  // Operand magnitudes for the engine and sign correction of its output.
  always_comb begin
    neg_a_s = op_a_signed(op_q) && rs1_q[XLEN-1];
    neg_b_s = op_b_signed(op_q) && rs2_q[XLEN-1];
    a_mag_s = cond_neg(rs1_q, neg_a_s);
    b_mag_s = cond_neg(rs2_q, neg_b_s);
    prod_s  = (neg_a_s ^ neg_b_s) ? (~acc_s + 64'd1) : acc_s;
    quo_s   = cond_neg(acc_s[XLEN-1:0], neg_a_s ^ neg_b_s);
    rem_s   = cond_neg(acc_s[2*XLEN-1:XLEN], neg_a_s);
    case (op_q)
      OP_MUL:                        fix_val_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_val_s = quo_s;
      OP_REM, OP_REMU:               fix_val_s = rem_s;
      default:                       fix_val_s = {XLEN{1'b0}};
    endcase
  end

  muldiv_iter u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  ((state_q == ST_CALC) && !bus.kill),
    .first_i (cnt_q == 6'd0),
    .div_i   (op_q[2]),
    .a_i     (a_mag_s),
    .b_i     (b_mag_s),
    .acc_o   (acc_s)
  );

  // FSM next state, operand latch, step counter and result staging.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    res_d    = res_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d  = bus.op;
          rs1_d = bus.rs1;
          rs2_d = bus.rs2;
          cnt_d = 6'd0;
          if (direct_s) begin
            res_d   = direct_val_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 6'(STEPS - 1)) begin
          cnt_d   = cnt_q + 6'd1;
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q + 6'd1;
        end
      end
      ST_FIX: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else begin
          res_d   = fix_val_s;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A kill here still lets the pulse already being produced go out.
        done_d   = 1'b1;
        result_d = res_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rs1_q    <= {XLEN{1'b0}};
      rs2_q    <= {XLEN{1'b0}};
      res_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      res_q    <= res_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
